// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode-in / fetch-out bundle between control unit, sequencer and imem/regfile (Resume only with HALT_RESUME_EN)
interface pc_sequencer_if #(
    parameter int PC_W  = 32,
    parameter int JMP_W = 26,
    parameter int OFF_W = 16
);
    logic             Jump;
    logic             JR;
    logic             JAL;
    logic             Branch;
    logic             Cond;
    logic             HLT;
    logic             In;
    logic [JMP_W-1:0] JmpTarget;
    logic [OFF_W-1:0] BrOffset;
    logic [PC_W-1:0]  RegRS;
    logic             InValid;
`ifdef HALT_RESUME_EN
    logic             Resume;
`endif
    logic [PC_W-1:0]  PC;
    logic [PC_W-1:0]  LinkAddr;
    logic             LinkWrite;
    logic             InReq;
    logic             InLoad;
    logic             Halted;
`ifdef HALT_RESUME_EN
    modport master (output Jump, JR, JAL, Branch, Cond, HLT, In, JmpTarget, BrOffset, RegRS, InValid, Resume,
                    input PC, LinkAddr, LinkWrite, InReq, InLoad, Halted);
    modport slave (input Jump, JR, JAL, Branch, Cond, HLT, In, JmpTarget, BrOffset, RegRS, InValid, Resume,
                   output PC, LinkAddr, LinkWrite, InReq, InLoad, Halted);
`else
    modport master (output Jump, JR, JAL, Branch, Cond, HLT, In, JmpTarget, BrOffset, RegRS, InValid,
                    input PC, LinkAddr, LinkWrite, InReq, InLoad, Halted);
    modport slave (input Jump, JR, JAL, Branch, Cond, HLT, In, JmpTarget, BrOffset, RegRS, InValid,
                   output PC, LinkAddr, LinkWrite, InReq, InLoad, Halted);
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, jump/branch/link sequencing, IN stall and HALT state (HALT_RESUME_EN adds Resume exit from HALT)
module pc_sequencer #(
    parameter int              PC_W     = 32,
    parameter int              JMP_W    = 26,
    parameter int              OFF_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic           clock,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] WAIT_IN = 2'd1;
    localparam logic [1:0] HALT    = 2'd2;

    logic [1:0]      state, next_state;
    logic [PC_W-1:0] pc, next_pc, pc_inc, br_tgt, jmp_tgt;
    logic            run, waiting, halted, jump_sel, br_sel, in_sel, resume;

    assign pc_inc   = pc + 1'b1;
    assign br_tgt   = pc_inc + {{(PC_W-OFF_W){bus.BrOffset[OFF_W-1]}}, bus.BrOffset};
    assign jmp_tgt  = {{(PC_W-JMP_W){1'b0}}, bus.JmpTarget};
    assign run      = state == RUN;
    assign waiting  = state == WAIT_IN;
    assign halted   = state == HALT;
    assign jump_sel = run & ~bus.HLT & bus.Jump;
    assign br_sel   = run & ~bus.HLT & ~bus.Jump & bus.Branch & bus.Cond;
    assign in_sel   = run & ~bus.HLT & ~bus.Jump & ~(bus.Branch & bus.Cond) & bus.In;
`ifdef HALT_RESUME_EN
    assign resume   = halted & bus.Resume;
`else
    assign resume   = 1'b0;
`endif

    assign bus.PC        = pc;
    assign bus.LinkAddr  = pc_inc;
    assign bus.LinkWrite = jump_sel & bus.JAL;
    assign bus.InReq     = waiting | in_sel;
    assign bus.InLoad    = (waiting | in_sel) & bus.InValid;
    assign bus.Halted    = halted;

    // next-state / next-PC selection in strict priority order; WAIT_IN and HALT ignore decode inputs
    always_comb begin
        next_state = state;
        next_pc    = pc;
        if (run) begin
            if (bus.HLT) next_state = HALT;
            else if (jump_sel) next_pc = bus.JR ? bus.RegRS : jmp_tgt;
            else if (br_sel) next_pc = br_tgt;
            else if (in_sel) begin
                next_pc    = bus.InValid ? pc_inc : pc;
                next_state = bus.InValid ? RUN : WAIT_IN;
            end else next_pc = pc_inc;
        end else if (waiting) begin
            next_pc    = bus.InValid ? pc_inc : pc;
            next_state = bus.InValid ? RUN : WAIT_IN;
        end else if (resume) begin
            next_pc    = pc_inc;
            next_state = RUN;
        end
    end

    // state and PC registers with synchronous reset taking priority over any state
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            pc    <= next_pc;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer with hand-computed expectations
module tb_pc_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.PC_W(32), .JMP_W(26), .OFF_W(16)) bus ();
    pc_sequencer #(.PC_W(32), .JMP_W(26), .OFF_W(16), .RESET_PC(32'd0)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear();
        bus.Jump = 0; bus.JR = 0; bus.JAL = 0; bus.Branch = 0; bus.Cond = 0;
        bus.HLT = 0; bus.In = 0; bus.InValid = 0;
        bus.JmpTarget = '0; bus.BrOffset = '0; bus.RegRS = '0;
`ifdef HALT_RESUME_EN
        bus.Resume = 0;
`endif
        #1;
    endtask

    task automatic jump_to(input logic [25:0] t);
        clear();
        bus.Jump = 1; bus.JmpTarget = t;
        step();
        clear();
    endtask

    initial begin
        clear();
        step(); step();
        reset = 0;
        #1;
        check("rst_pc", bus.PC, 32'd0);
        check("rst_halted", {31'd0, bus.Halted}, 32'd0);
        check("rst_inreq", {31'd0, bus.InReq}, 32'd0);
        check("rst_inload", {31'd0, bus.InLoad}, 32'd0);
        check("rst_linkwrite", {31'd0, bus.LinkWrite}, 32'd0);
        check("rst_linkaddr", bus.LinkAddr, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_pc", bus.PC, i);
        end
        step(); step();
        check("pc5", bus.PC, 32'd5);
        bus.Branch = 1; bus.Cond = 1; bus.BrOffset = 16'hFFFD;
        #1;
        check("br_no_link", {31'd0, bus.LinkWrite}, 32'd0);
        step();
        check("br_taken", bus.PC, 32'd3);
        clear();
        step(); step();
        bus.Branch = 1; bus.Cond = 0; bus.BrOffset = 16'hFFFD;
        step();
        check("br_not_taken", bus.PC, 32'd6);
        jump_to(26'd10);
        check("jmp10", bus.PC, 32'd10);
        bus.Jump = 1; bus.JAL = 1; bus.JmpTarget = 26'd40;
        #1;
        check("jal_linkwrite", {31'd0, bus.LinkWrite}, 32'd1);
        check("jal_linkaddr", bus.LinkAddr, 32'd11);
        step();
        check("jal_pc", bus.PC, 32'd40);
        clear();
        bus.Jump = 1; bus.JR = 1; bus.RegRS = 32'd11; bus.JmpTarget = 26'd77;
        #1;
        check("jr_no_link", {31'd0, bus.LinkWrite}, 32'd0);
        step();
        check("jr_pc", bus.PC, 32'd11);
        jump_to(26'd7);
        bus.In = 1; bus.InValid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("in_wait_req", {31'd0, bus.InReq}, 32'd1);
            check("in_wait_pc", bus.PC, 32'd7);
            check("in_wait_load", {31'd0, bus.InLoad}, 32'd0);
            step();
            if (i == 0) begin
                bus.In = 0; bus.Jump = 1; bus.JmpTarget = 26'd99;
            end
        end
        check("in_ignore_pc", bus.PC, 32'd7);
        clear();
        bus.InValid = 1;
        #1;
        check("in_load", {31'd0, bus.InLoad}, 32'd1);
        step();
        clear();
        check("in_done_pc", bus.PC, 32'd8);
        check("in_done_load", {31'd0, bus.InLoad}, 32'd0);
        check("in_done_req", {31'd0, bus.InReq}, 32'd0);
        bus.In = 1; bus.InValid = 1;
        #1;
        check("in_fast_load", {31'd0, bus.InLoad}, 32'd1);
        step();
        clear();
        check("in_fast_pc", bus.PC, 32'd9);
        bus.HLT = 1; bus.Jump = 1; bus.JAL = 1; bus.JmpTarget = 26'd50;
        #1;
        check("hlt_no_link", {31'd0, bus.LinkWrite}, 32'd0);
        check("hlt_not_yet", {31'd0, bus.Halted}, 32'd0);
        step();
        clear();
        check("hlt_pc", bus.PC, 32'd9);
        check("hlt_halted", {31'd0, bus.Halted}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.Jump = ~bus.Jump; bus.JmpTarget = 26'd50; bus.In = 1; bus.JAL = 1;
            #1;
            check("halt_req", {31'd0, bus.InReq}, 32'd0);
            check("halt_link", {31'd0, bus.LinkWrite}, 32'd0);
            step();
            check("halt_pc", bus.PC, 32'd9);
            check("halt_flag", {31'd0, bus.Halted}, 32'd1);
        end
        clear();
`ifdef HALT_RESUME_EN
        bus.Resume = 1;
        step();
        clear();
        check("resume_pc", bus.PC, 32'd10);
        check("resume_halted", {31'd0, bus.Halted}, 32'd0);
`else
        step(); step();
        check("still_halted", {31'd0, bus.Halted}, 32'd1);
        check("still_pc", bus.PC, 32'd9);
`endif
        reset = 1;
        step();
        reset = 0;
        check("rst_halt_pc", bus.PC, 32'd0);
        check("rst_halt_flag", {31'd0, bus.Halted}, 32'd0);
        jump_to(26'd4);
        bus.In = 1; bus.InValid = 0;
        step();
        bus.In = 0;
        #1;
        check("wait_req", {31'd0, bus.InReq}, 32'd1);
        check("wait_pc", bus.PC, 32'd4);
        reset = 1;
        step();
        reset = 0;
        #1;
        check("rst_wait_pc", bus.PC, 32'd0);
        check("rst_wait_req", {31'd0, bus.InReq}, 32'd0);
        step();
        check("rst_wait_run", bus.PC, 32'd1);
        bus.Jump = 1; bus.JR = 1; bus.RegRS = 32'hFFFF_FFFF;
        step();
        clear();
        check("wrap_pre", bus.PC, 32'hFFFF_FFFF);
        check("wrap_link", bus.LinkAddr, 32'd0);
        step();
        check("wrap_pc", bus.PC, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
